// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl -- UART transmit frame sequencer
//
// Accepts one character over a valid/ready handshake. It then shifts out a
// serial frame on txd in this order: start bit (0), 5..8 data bits LSB-first,
// an optional parity bit, then one or two stop bits (1). The configuration is
// captured when the handshake happens, so later input changes do not affect
// the frame already in flight.
//
// Parameters
//   DSIZE  data port width (maximum data bits per frame)
//   DIV_W  width of the baud divisor
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset; aborts any frame, txd -> 1
//   baud_div   bit period minus one, in clk cycles
//   bit_width  data bits per frame; 5..8 legal, anything else means 8
//   parity_en  1 = append a parity bit after the data bits
//   odd_even   0 = even parity, 1 = odd parity
//   stop2      0 = one stop bit, 1 = two stop bits
//   tx_data    character to send
//   tx_valid   tx_data is valid
//   tx_ready   block can accept a character (high only in IDLE)
//   txd        registered serial output, idle high
//   busy       frame in progress (inverse of tx_ready)
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int DSIZE = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       bit_width,
  input  logic             parity_en,
  input  logic             odd_even,
  input  logic             stop2,
  input  logic [DSIZE-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             txd,
  output logic             busy
);

  // Frame states; the encoding is fixed so that register dumps stay readable.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  // Largest data width the port can carry, capped at the 8-bit UART maximum.
  localparam logic [3:0] MAX_BW = (DSIZE < 8) ? 4'(DSIZE) : 4'd8;

  // ---------------------------------------------------------------------------
  // State and frame configuration captured at the handshake
  // ---------------------------------------------------------------------------
  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [DIV_W-1:0] div_lat;     // bit period minus one for this frame
  logic [3:0]       bw_lat;      // sanitised data width for this frame
  logic             par_en_lat;
  logic             stop2_lat;
  logic             par_bit;     // parity bit precomputed at the handshake
  logic             par_bit_next;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_cnt_next;
  logic [3:0]       bit_cnt;
  logic [3:0]       bit_cnt_next;
  logic [DSIZE-1:0] shift_reg;
  logic [DSIZE-1:0] shift_next;
  logic             txd_next;

  // ---------------------------------------------------------------------------
  // Decoded conditions
  // ---------------------------------------------------------------------------
  logic             handshake;
  logic             bit_end;
  logic             last_data_bit;
  logic [3:0]       bw_san;
  logic [DSIZE-1:0] width_mask;

  // The ready/busy flags are straight decodes of the registered state, so they
  // change on exactly the edge that enters or leaves IDLE.
  assign tx_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign handshake = tx_valid && tx_ready;

  // A bit period ends when the divider reaches the captured divisor. With a
  // divisor of zero every clock ends a bit.
  assign bit_end       = (state != IDLE) && (div_cnt == div_lat);
  assign last_data_bit = (bit_cnt == (bw_lat - 4'd1));

  // ---------------------------------------------------------------------------
  // Width sanitising and parity precompute
  //
  // The parity bit covers only the active data bits. It is computed from the
  // live inputs at the handshake and stored. That gives the same result as
  // XOR-ing the captured data later, without keeping a second copy of the
  // character next to the shift register.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    bw_san     = MAX_BW;
    width_mask = '0;
    if ((bit_width >= 4'd5) && (bit_width <= MAX_BW)) begin
      bw_san = bit_width;
    end
    for (int i = 0; i < DSIZE; i++) begin
      width_mask[i] = (i < int'(bw_san));
    end
    par_bit_next = (^(tx_data & width_mask)) ^ odd_even;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end && last_data_bit) begin
          state_next = par_en_lat ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP1;
        end
      end
      STOP1: begin
        if (bit_end) begin
          state_next = stop2_lat ? STOP2 : IDLE;
        end
      end
      STOP2: begin
        if (bit_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter and shift register next values
  // ---------------------------------------------------------------------------
  always_comb begin
    // The divider restarts at every bit boundary and stays cleared in IDLE.
    // The handshake edge therefore enters START with a fresh count.
    div_cnt_next = div_cnt + DIV_W'(1);
    if ((state == IDLE) || bit_end) begin
      div_cnt_next = '0;
    end

    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    if (handshake) begin
      bit_cnt_next = '0;
      shift_next   = tx_data;
    end else if ((state == DATA) && bit_end) begin
      bit_cnt_next = last_data_bit ? 4'd0 : (bit_cnt + 4'd1);
      shift_next   = {1'b0, shift_reg[DSIZE-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Serial output, computed for the state being entered
  //
  // txd is registered, so it takes the value belonging to state_next. In DATA
  // that value is bit 0 of the next shift register contents. This covers the
  // first data bit (no shift yet) and every later bit (shifted on the
  // boundary) alike.
  // ---------------------------------------------------------------------------
  always_comb begin
    txd_next = 1'b1;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      PARITY:  txd_next = par_bit;
      default: txd_next = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge, whatever the
    // statement order.
    if (!rst_n) begin
      state      <= IDLE;
      txd        <= 1'b1;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      div_lat    <= '0;
      bw_lat     <= '0;
      par_en_lat <= 1'b0;
      stop2_lat  <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      state     <= state_next;
      txd       <= txd_next;
      div_cnt   <= div_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
      if (handshake) begin
        div_lat    <= baud_div;
        bw_lat     <= bw_san;
        par_en_lat <= parity_en;
        stop2_lat  <= stop2;
        par_bit    <= par_bit_next;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl -- directed bench for uart_tx_ctrl
//
// Each scenario task starts a frame and records txd/tx_ready/busy at every
// falling clock edge. It then compares the record against a hand-written bit
// sequence, with each bit held for baud_div+1 clocks.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int DSIZE = 8;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic [3:0]       bit_width = 4'd8;
  logic             parity_en = 1'b0;
  logic             odd_even = 1'b0;
  logic             stop2 = 1'b0;
  logic [DSIZE-1:0] tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic             txd;
  logic             busy;

  int checks = 0;
  int failures = 0;

  logic txq[$];
  logic rdq[$];
  logic bzq[$];

  uart_tx_ctrl #(.DSIZE(DSIZE), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_div  (baud_div),
    .bit_width (bit_width),
    .parity_en (parity_en),
    .odd_even  (odd_even),
    .stop2     (stop2),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .txd       (txd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected normal end");
    $fatal(1);
  end

  task automatic clear_logs();
    txq.delete();
    rdq.delete();
    bzq.delete();
  endtask

  // Record n falling-edge samples of the outputs.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txq.push_back(txd);
      rdq.push_back(tx_ready);
      bzq.push_back(busy);
    end
  endtask

  // Present one character with a single-cycle tx_valid. The handshake edge
  // is the rising edge right after the inputs are applied.
  task automatic start_frame(input logic [7:0] d, input logic [3:0] bw,
                             input logic pe, input logic oe, input logic s2,
                             input logic [15:0] div);
    @(negedge clk);
    tx_data   = d;
    bit_width = bw;
    parity_en = pe;
    odd_even  = oe;
    stop2     = s2;
    baud_div  = div;
    tx_valid  = 1'b1;
    @(posedge clk);
    #1;
    tx_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({txd, tx_ready, busy} !== 3'b110) begin
      failures++;
      $display("FAIL reset_outputs: txd/ready/busy=%b%b%b expected 110", txd, tx_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    capture(3);
    checks++;
    if ({txq[2], rdq[2], bzq[2]} !== 3'b110) begin
      failures++;
      $display("FAIL reset_idle: txd/ready/busy=%b%b%b expected 110", txq[2], rdq[2], bzq[2]);
    end
  endtask

  // A5, 8 bits, no parity, 1 stop, 4 clocks per bit.
  task automatic test_basic();
    logic [0:9] e;
    int lows;
    bit bad;
    e = 10'b0101001011;
    clear_logs();
    start_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 16'd3);
    capture(41);
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      for (int k = 0; k < 4; k++) if (txq[b*4+k] !== e[b]) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL basic_bit%0d: txd=%b%b%b%b expected %b x4", b,
                 txq[b*4], txq[b*4+1], txq[b*4+2], txq[b*4+3], e[b]);
      end
    end
    lows = 0;
    for (int i = 0; i < 40; i++) if (rdq[i] === 1'b0) lows++;
    checks++;
    if (lows != 40) begin
      failures++;
      $display("FAIL basic_ready_low: low for %0d clocks, expected 40", lows);
    end
    checks++;
    if ({txq[40], rdq[40], bzq[40]} !== 3'b110) begin
      failures++;
      $display("FAIL basic_end_idle: txd/ready/busy=%b%b%b expected 110", txq[40], rdq[40], bzq[40]);
    end
    checks++;
    if (bzq[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: busy=%b expected 1", bzq[0]);
    end
  endtask

  // 07 with even parity (bit 1) and odd parity (bit 0), 3 clocks per bit.
  task automatic test_parity();
    logic [0:10] e;
    bit bad;
    for (int oe = 0; oe < 2; oe++) begin
      e = (oe == 0) ? 11'b01110000011 : 11'b01110000001;
      clear_logs();
      start_frame(8'h07, 4'd8, 1'b1, oe[0], 1'b0, 16'd2);
      capture(34);
      for (int b = 0; b < 11; b++) begin
        bad = 1'b0;
        for (int k = 0; k < 3; k++) if (txq[b*3+k] !== e[b]) bad = 1'b1;
        checks++;
        if (bad) begin
          failures++;
          $display("FAIL parity%0d_bit%0d: txd=%b%b%b expected %b x3", oe, b,
                   txq[b*3], txq[b*3+1], txq[b*3+2], e[b]);
        end
      end
      checks++;
      if ({txq[33], rdq[33], rdq[32]} !== 3'b110) begin
        failures++;
        $display("FAIL parity%0d_length: txd/ready@33=%b%b ready@32=%b expected 11 0",
                 oe, txq[33], rdq[33], rdq[32]);
      end
    end
  endtask

  // FF, 5 bits, even parity, two stops, one clock per bit.
  task automatic test_short_frame();
    logic [0:8] e;
    e = 9'b011111111;
    clear_logs();
    start_frame(8'hFF, 4'd5, 1'b1, 1'b0, 1'b1, 16'd0);
    capture(10);
    for (int b = 0; b < 9; b++) begin
      checks++;
      if (txq[b] !== e[b]) begin
        failures++;
        $display("FAIL short_bit%0d: txd=%b expected %b", b, txq[b], e[b]);
      end
    end
    checks++;
    if ({rdq[8], rdq[9], txq[9]} !== 3'b011) begin
      failures++;
      $display("FAIL short_length: ready@8=%b ready@9=%b txd@9=%b expected 0 1 1",
               rdq[8], rdq[9], txq[9]);
    end
  endtask

  // Illegal width 3 falls back to 8 data bits.
  task automatic test_bw_sanitise();
    logic [0:9] e;
    bit bad;
    e = 10'b0100000011;
    clear_logs();
    start_frame(8'h81, 4'd3, 1'b0, 1'b0, 1'b0, 16'd1);
    capture(21);
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      for (int k = 0; k < 2; k++) if (txq[b*2+k] !== e[b]) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL bw3_bit%0d: txd=%b%b expected %b x2", b, txq[b*2], txq[b*2+1], e[b]);
      end
    end
    checks++;
    if ({rdq[19], rdq[20]} !== 2'b01) begin
      failures++;
      $display("FAIL bw3_length: ready@19,20=%b%b expected 01", rdq[19], rdq[20]);
    end
  endtask

  // tx_valid held high: 55 (8 bits) then AA. bit_width changes to 5 during
  // frame 1, so frame 1 stays 8 bits and frame 2 carries 5 bits.
  task automatic test_back_to_back();
    logic [0:9] e1;
    logic [0:6] e2;
    bit bad;
    e1 = 10'b0101010101;
    e2 = 7'b0010101;
    clear_logs();
    @(negedge clk);
    tx_data   = 8'h55;
    bit_width = 4'd8;
    parity_en = 1'b0;
    odd_even  = 1'b0;
    stop2     = 1'b0;
    baud_div  = 16'd1;
    tx_valid  = 1'b1;
    @(posedge clk);
    #1;
    tx_data   = 8'hAA;
    bit_width = 4'd5;
    capture(21);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    capture(15);
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      for (int k = 0; k < 2; k++) if (txq[b*2+k] !== e1[b]) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL b2b_f1_bit%0d: txd=%b%b expected %b x2", b, txq[b*2], txq[b*2+1], e1[b]);
      end
    end
    checks++;
    if ({txq[20], rdq[20], rdq[19], rdq[21]} !== 4'b1100) begin
      failures++;
      $display("FAIL b2b_gap: txd/ready@20=%b%b ready@19=%b ready@21=%b expected 11 0 0",
               txq[20], rdq[20], rdq[19], rdq[21]);
    end
    for (int b = 0; b < 7; b++) begin
      bad = 1'b0;
      for (int k = 0; k < 2; k++) if (txq[21+b*2+k] !== e2[b]) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL b2b_f2_bit%0d: txd=%b%b expected %b x2", b,
                 txq[21+b*2], txq[22+b*2], e2[b]);
      end
    end
    checks++;
    if ({txq[35], rdq[35], rdq[34]} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_f2_length: txd/ready@35=%b%b ready@34=%b expected 11 0",
               txq[35], rdq[35], rdq[34]);
    end
  endtask

  // Reset during data bit 3 of A5, then a clean 0D frame:
  // 6 bits, odd parity, two stops, one clock per bit.
  task automatic test_reset_mid_frame();
    logic [0:9] e;
    e = 10'b0101100011;
    clear_logs();
    start_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 16'd3);
    capture(18);
    checks++;
    if ({txq[17], rdq[17]} !== 2'b00) begin
      failures++;
      $display("FAIL abort_pre: txd/ready=%b%b expected 00", txq[17], rdq[17]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({txd, tx_ready, busy} !== 3'b110) begin
      failures++;
      $display("FAIL abort_async: txd/ready/busy=%b%b%b expected 110", txd, tx_ready, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    start_frame(8'h0D, 4'd6, 1'b1, 1'b1, 1'b1, 16'd0);
    capture(11);
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (txq[b] !== e[b]) begin
        failures++;
        $display("FAIL abort_new_bit%0d: txd=%b expected %b", b, txq[b], e[b]);
      end
    end
    checks++;
    if ({rdq[9], rdq[10], txq[10]} !== 3'b011) begin
      failures++;
      $display("FAIL abort_new_length: ready@9=%b ready@10=%b txd@10=%b expected 0 1 1",
               rdq[9], rdq[10], txq[10]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_short_frame();
    test_bw_sanitise();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
